// File: rtl/mm_rf_pkg.sv
// mm_rf_pkg: shared register-file writeback types and constants
package mm_rf_pkg;
  localparam int REG_ADDR_W = 4;
  localparam int NUM_ARCH_REGS = 16;
  localparam int PC_IDX = 15;
  localparam int WB_DATA_W = 32;
  typedef enum logic {WB_ALU, WB_MEM} wb_src_e;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: pending-write vector with issue stall, read hazards and unissued-writeback error
module wb_scoreboard
  import mm_rf_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              issue_stall,
  input  logic [ADDR_W-1:0] rd_a1,
  input  logic [ADDR_W-1:0] rd_a2,
  output logic              hazard1,
  output logic              hazard2,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic              acc_en,
  input  logic [ADDR_W-1:0] acc_addr,
  output logic              err_unissued
);
  localparam int NUM = 1 << ADDR_W;
  logic [NUM-1:0] pending_q, pending_d;
  logic err_q, err_d;
  always_comb begin
    issue_stall = issue_valid && pending_q[issue_addr];
    hazard1 = pending_q[rd_a1];
    hazard2 = pending_q[rd_a2];
    err_d = err_q || (acc_en && !pending_q[acc_addr]);
    pending_d = pending_q;
    if (clr_en) pending_d[clr_addr] = 1'b0;
    // a fresh issue landing on the committing register must survive the clear
    if (issue_valid && !issue_stall) pending_d[issue_addr] = 1'b1;
  end
  always_ff @(posedge clk) begin
    pending_q <= rst ? '0 : pending_d;
    err_q <= rst ? 1'b0 : err_d;
  end
  assign err_unissued = err_q;
endmodule

// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter: round-robin ALU/MEM share of the RF write port, R15 redirected to the PC
module rf_writeback_arbiter
  import mm_rf_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int PC_IDX = mm_rf_pkg::PC_IDX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              issue_stall,
  input  logic [ADDR_W-1:0] rd_a1,
  input  logic [ADDR_W-1:0] rd_a2,
  output logic              hazard1,
  output logic              hazard2,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_a3,
  output logic [DATA_W-1:0] rf_wd3,
  output logic              pc_we,
  output logic [DATA_W-1:0] pc_wd,
  output logic              err_unissued
);
  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);
  wb_src_e last_grant_q, last_grant_d;
  logic rf_we_q, rf_we_d, pc_we_q, pc_we_d, acc, is_pc;
  logic [ADDR_W-1:0] rf_a3_q, rf_a3_d, g_addr, clr_addr;
  logic [DATA_W-1:0] rf_wd3_q, rf_wd3_d, pc_wd_q, pc_wd_d, g_data;
  always_comb begin
    alu_ready = alu_valid && (!mem_valid || last_grant_q == WB_MEM);
    mem_ready = mem_valid && (!alu_valid || last_grant_q == WB_ALU);
    acc = alu_ready || mem_ready;
    g_addr = alu_ready ? alu_addr : mem_addr;
    g_data = alu_ready ? alu_data : mem_data;
    is_pc = g_addr == PC_A;
    last_grant_d = alu_ready ? WB_ALU : mem_ready ? WB_MEM : last_grant_q;
    rf_we_d = acc && !is_pc;
    pc_we_d = acc && is_pc;
    rf_a3_d = rf_we_d ? g_addr : rf_a3_q;
    rf_wd3_d = rf_we_d ? g_data : rf_wd3_q;
    pc_wd_d = pc_we_d ? g_data : pc_wd_q;
    clr_addr = pc_we_q ? PC_A : rf_a3_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= WB_MEM;
      rf_we_q <= 1'b0;
      pc_we_q <= 1'b0;
      rf_a3_q <= '0;
      rf_wd3_q <= '0;
      pc_wd_q <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_we_q <= rf_we_d;
      pc_we_q <= pc_we_d;
      rf_a3_q <= rf_a3_d;
      rf_wd3_q <= rf_wd3_d;
      pc_wd_q <= pc_wd_d;
    end
  end
  assign rf_we = rf_we_q;
  assign rf_a3 = rf_a3_q;
  assign rf_wd3 = rf_wd3_q;
  assign pc_we = pc_we_q;
  assign pc_wd = pc_wd_q;
  wb_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk(clk),
    .rst(rst),
    .issue_valid(issue_valid),
    .issue_addr(issue_addr),
    .issue_stall(issue_stall),
    .rd_a1(rd_a1),
    .rd_a2(rd_a2),
    .hazard1(hazard1),
    .hazard2(hazard2),
    .clr_en(rf_we_q || pc_we_q),
    .clr_addr(clr_addr),
    .acc_en(acc),
    .acc_addr(g_addr),
    .err_unissued(err_unissued)
  );
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// tb_rf_writeback_arbiter: directed vectors with hand-computed expectations
module tb_rf_writeback_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic alu_valid, mem_valid, issue_valid;
  logic [3:0] alu_addr, mem_addr, issue_addr, rd_a1, rd_a2;
  logic [31:0] alu_data, mem_data;
  logic alu_ready, mem_ready, issue_stall, hazard1, hazard2, rf_we, pc_we, err_unissued;
  logic [3:0] rf_a3;
  logic [31:0] rf_wd3, pc_wd;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  rf_writeback_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_stall(issue_stall),
    .rd_a1(rd_a1), .rd_a2(rd_a2), .hazard1(hazard1), .hazard2(hazard2),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd3(rf_wd3),
    .pc_we(pc_we), .pc_wd(pc_wd), .err_unissued(err_unissued)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [3:0] a);
    issue_valid = 1'b1;
    issue_addr = a;
    tick();
    issue_valid = 1'b0;
  endtask
  initial begin
    logic a, m;
    logic [3:0] exp_a3 [4] = '{4'd1, 4'd4, 4'd2, 4'd3};
    logic exp_alu [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    rst = 1'b1;
    {alu_valid, mem_valid, issue_valid} = '0;
    {alu_addr, mem_addr, issue_addr, rd_a1, rd_a2} = '0;
    alu_data = '0;
    mem_data = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_rf_we", rf_we, 0);
    check("rst_pc_we", pc_we, 0);
    check("rst_err", err_unissued, 0);
    check("rst_a3", rf_a3, 0);
    check("rst_wd3", rf_wd3, 0);
    check("rst_pc_wd", pc_wd, 0);
    issue(4'd3);
    issue(4'd5);
    alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 32'h11;
    mem_valid = 1'b1; mem_addr = 4'd5; mem_data = 32'h22;
    #1;
    check("t1_alu_ready0", alu_ready, 1);
    check("t1_mem_ready0", mem_ready, 0);
    tick();
    alu_valid = 1'b0;
    rd_a1 = 4'd3;
    #1;
    check("t1_mem_ready1", mem_ready, 1);
    check("t1_we_a", rf_we, 1);
    check("t1_a3_a", rf_a3, 3);
    check("t1_wd3_a", rf_wd3, 32'h11);
    check("t1_haz3_commit", hazard1, 1);
    tick();
    mem_valid = 1'b0;
    rd_a2 = 4'd5;
    #1;
    check("t1_we_b", rf_we, 1);
    check("t1_a3_b", rf_a3, 5);
    check("t1_wd3_b", rf_wd3, 32'h22);
    check("t1_haz3_clear", hazard1, 0);
    check("t1_haz5_commit", hazard2, 1);
    tick();
    check("t1_idle_we", rf_we, 0);
    check("t1_haz5_clear", hazard2, 0);
    check("t1_a3_hold", rf_a3, 5);
    for (int i = 1; i <= 4; i++) issue(4'(i));
    alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 32'ha1;
    mem_valid = 1'b1; mem_addr = 4'd4; mem_data = 32'hb4;
    for (int i = 0; i < 4; i++) begin
      #1;
      a = alu_ready;
      m = mem_ready;
      check("t2_one_ready", a & m, 0);
      check("t2_alu_grant", a, exp_alu[i]);
      check("t2_mem_grant", m, !exp_alu[i]);
      tick();
      check("t2_a3", rf_a3, exp_a3[i]);
      check("t2_we", rf_we, 1);
      if (a) begin
        alu_addr = alu_addr + 4'd1;
        alu_data = alu_data + 32'd1;
        if (alu_addr == 4'd4) alu_valid = 1'b0;
      end
      if (m) mem_valid = 1'b0;
    end
    tick();
    check("t2_err_clean", err_unissued, 0);
    issue(4'd15);
    rd_a1 = 4'd15;
    #1;
    check("t3_haz15_pending", hazard1, 1);
    mem_valid = 1'b1; mem_addr = 4'd15; mem_data = 32'h100;
    #1;
    check("t3_mem_ready", mem_ready, 1);
    tick();
    mem_valid = 1'b0;
    check("t3_pc_we", pc_we, 1);
    check("t3_pc_wd", pc_wd, 32'h100);
    check("t3_rf_we", rf_we, 0);
    check("t3_haz15_commit", hazard1, 1);
    tick();
    check("t3_pc_we_off", pc_we, 0);
    check("t3_haz15_clear", hazard1, 0);
    check("t3_pc_wd_hold", pc_wd, 32'h100);
    issue_valid = 1'b1; issue_addr = 4'd7;
    #1;
    check("t4_first_issue", issue_stall, 0);
    tick();
    check("t4_waw_stall", issue_stall, 1);
    tick();
    issue_valid = 1'b0;
    rd_a1 = 4'd7;
    #1;
    check("t4_haz7", hazard1, 1);
    alu_valid = 1'b1; alu_addr = 4'd7; alu_data = 32'h77;
    tick();
    alu_valid = 1'b0;
    check("t4_a3", rf_a3, 7);
    check("t4_wd3", rf_wd3, 32'h77);
    tick();
    check("t4_haz7_clear", hazard1, 0);
    check("t4_err_clean", err_unissued, 0);
    mem_valid = 1'b1; mem_addr = 4'd9; mem_data = 32'h99;
    #1;
    check("t5_mem_ready", mem_ready, 1);
    tick();
    mem_valid = 1'b0;
    check("t5_we", rf_we, 1);
    check("t5_a3", rf_a3, 9);
    check("t5_wd3", rf_wd3, 32'h99);
    check("t5_err_set", err_unissued, 1);
    issue_valid = 1'b1; issue_addr = 4'd9;
    #1;
    check("t5_issue9_nostall", issue_stall, 0);
    tick();
    issue_valid = 1'b0;
    rd_a1 = 4'd9;
    #1;
    check("t5_set_wins", hazard1, 1);
    tick();
    tick();
    check("t5_err_sticky", err_unissued, 1);
    issue(4'd2);
    alu_valid = 1'b1; alu_addr = 4'd2; alu_data = 32'h22;
    tick();
    check("t6_pre_we", rf_we, 1);
    rst = 1'b1;
    alu_data = 32'h23;
    #1;
    check("t6_ready_in_rst", alu_ready, 1);
    tick();
    rst = 1'b0;
    alu_valid = 1'b0;
    #1;
    check("t6_we_dropped", rf_we, 0);
    check("t6_a3_cleared", rf_a3, 0);
    check("t6_wd3_cleared", rf_wd3, 0);
    check("t6_err_cleared", err_unissued, 0);
    tick();
    check("t6_we_still_off", rf_we, 0);
    for (int i = 0; i < 16; i++) begin
      rd_a1 = 4'(i);
      rd_a2 = 4'(15 - i);
      #1;
      check("t6_haz1_zero", hazard1, 0);
      check("t6_haz2_zero", hazard2, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
